sm_neuron_accumulator: RTL and testbench

- Downstream consumer of the sign-magnitude 8x8 multiplier stage. Takes one 15-bit product per handshake and accumulates TERMS products plus a bias into a signed two's-complement sum.
- After the last term it rescales the sum, applies ReLU and saturation, and emits an 8-bit sign-magnitude activation for the next layer's multipliers.
- One instance serves one neuron evaluation at a time.

---
 rtl/sm_neuron_accumulator.sv | 104 ++++++++++
 tb/tb_sm_neuron_accumulator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_neuron_accumulator.sv
// Neuron accumulator: sums TERMS sign-magnitude products onto a bias with saturation,
// then emits the rescaled, ReLU'd, saturated 8-bit sign-magnitude activation.
module sm_neuron_accumulator #(
    parameter int BIT    = 8,
    parameter int PROD_W = 2*BIT-1,
    parameter int TERMS  = 784,
    parameter int ACC_W  = 32,
    parameter int SHIFT  = 7
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic [ACC_W-1:0]  iBias,
    input  logic              iValid,
    input  logic [PROD_W-1:0] iProduct,
    output logic              oReady,
    output logic              oValid,
    output logic [ACC_W-1:0]  oSum,
    output logic [BIT-1:0]    oAct,
    output logic              oBusy
);
    localparam int CNT_W = $clog2(TERMS+1);
    localparam int MAG_W = PROD_W-1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TERMS-1);
    localparam logic [ACC_W-1:0] ACT_MAX = {{(ACC_W-BIT+1){1'b0}}, {(BIT-1){1'b1}}};
    localparam logic [ACC_W-1:0] POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] NEG_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_sum;
    logic [BIT-1:0]     r_act;

    logic [ACC_W:0]     w_mag_ext;
    logic [ACC_W:0]     w_term;
    logic [ACC_W:0]     w_sum_wide;
    logic [ACC_W-1:0]   w_sum_sat;
    logic [ACC_W-1:0]   w_shift;
    logic [BIT-1:0]     w_act;

    // One guard bit above the accumulator is enough: |term| < 2^(PROD_W-1) << 2^(ACC_W-1).
    always_comb begin
        w_mag_ext  = {{(ACC_W+1-MAG_W){1'b0}}, iProduct[MAG_W-1:0]};
        w_term     = iProduct[PROD_W-1] ? (~w_mag_ext + 1'b1) : w_mag_ext;
        w_sum_wide = {r_acc[ACC_W-1], r_acc} + w_term;
        case (w_sum_wide[ACC_W:ACC_W-1])
            2'b01:   w_sum_sat = POS_MAX;
            2'b10:   w_sum_sat = NEG_MIN;
            default: w_sum_sat = w_sum_wide[ACC_W-1:0];
        endcase
    end

    always_comb begin
        w_shift = w_sum_sat >> SHIFT;
        if (w_sum_sat[ACC_W-1] || (w_sum_sat == '0))
            w_act = '0;
        else if (w_shift > ACT_MAX)
            w_act = {1'b0, {(BIT-1){1'b1}}};
        else
            w_act = {1'b0, w_shift[BIT-2:0]};
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_act   <= '0;
        end else if (iStart) begin
            // Start is accepted in every state; in ACC it aborts and drops this cycle's product.
            r_state <= S_ACC;
            r_acc   <= iBias;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_act   <= '0;
        end else begin
            case (r_state)
                S_ACC: begin
                    if (iValid) begin
                        r_acc <= w_sum_sat;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_state <= S_DONE;
                            r_sum   <= w_sum_sat;
                            r_act   <= w_act;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oReady = (r_state == S_ACC);
    assign oValid = (r_state == S_DONE);
    assign oBusy  = (r_state != S_IDLE);
    assign oSum   = r_sum;
    assign oAct   = r_act;
endmodule

// File: tb/tb_sm_neuron_accumulator.sv
// Bench for sm_neuron_accumulator: constant vectors, directed corner sequences and
// random neurons checked every cycle against a queue-based reference model.
module tb_sm_neuron_accumulator;
    localparam int TERMS = 4;
    localparam int SHIFT = 7;

    logic        iClk = 1'b0;
    logic        iRst, iStart, iValid;
    logic [31:0] iBias;
    logic [15:0] iBias16;
    logic [14:0] iProduct;
    logic        oReady, oValid, oBusy;
    logic [31:0] oSum;
    logic [7:0]  oAct;
    logic        oReady16, oValid16, oBusy16;
    logic [15:0] oSum16;
    logic [7:0]  oAct16;

    sm_neuron_accumulator #(.BIT(8), .TERMS(TERMS), .ACC_W(32), .SHIFT(SHIFT)) u_dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iBias(iBias), .iValid(iValid),
        .iProduct(iProduct), .oReady(oReady), .oValid(oValid), .oSum(oSum),
        .oAct(oAct), .oBusy(oBusy));

    sm_neuron_accumulator #(.BIT(8), .TERMS(TERMS), .ACC_W(16), .SHIFT(SHIFT)) u_dut16 (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iBias(iBias16), .iValid(iValid),
        .iProduct(iProduct), .oReady(oReady16), .oValid(oValid16), .oSum(oSum16),
        .oAct(oAct16), .oBusy(oBusy16));

    always #5 iClk = ~iClk;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          m_active = 0;
    bit          m_vnext  = 0;
    logic [14:0] q[$];
    longint      m_b32, m_b16;
    logic [31:0] e_sum   = '0;
    logic [7:0]  e_act   = '0;
    logic [15:0] e_sum16 = '0;
    logic [7:0]  e_act16 = '0;

    typedef struct {
        logic [31:0]       bias;
        logic [3:0][14:0]  p;
        logic [31:0]       sum;
        logic [7:0]        act;
        logic [15:0]       sum16;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [31:0] b, logic [14:0] p0, logic [14:0] p1,
                                logic [14:0] p2, logic [14:0] p3,
                                logic [31:0] s, logic [7:0] a, logic [15:0] s16);
        vec_t v;
        v.bias = b; v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
        v.sum = s; v.act = a; v.sum16 = s16;
        return v;
    endfunction

    function automatic longint ref_sum(longint b, int w);
        longint hi = (longint'(1) << (w-1)) - 1;
        longint lo = -(longint'(1) << (w-1));
        longint s  = b;
        foreach (q[i]) begin
            longint m = longint'(q[i][13:0]);
            s = q[i][14] ? s - m : s + m;
            if (s > hi) s = hi;
            if (s < lo) s = lo;
        end
        return s;
    endfunction

    function automatic logic [7:0] ref_act(longint s);
        longint m;
        if (s <= 0) return 8'h00;
        m = s >>> SHIFT;
        if (m > 127) return 8'h7f;
        return 8'(m);
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_outs();
        chk("valid", {63'd0, oValid}, {63'd0, m_vnext});
        chk("ready", {63'd0, oReady}, {63'd0, m_active});
        chk("busy",  {63'd0, oBusy},  {63'd0, m_active | m_vnext});
        chk("sum",   {32'd0, oSum},   {32'd0, e_sum});
        chk("act",   {56'd0, oAct},   {56'd0, e_act});
        chk("valid16", {63'd0, oValid16}, {63'd0, m_vnext});
        chk("sum16", {48'd0, oSum16}, {48'd0, e_sum16});
        chk("act16", {56'd0, oAct16}, {56'd0, e_act16});
    endtask

    // Drive one cycle, advance the model by the spec's rules, then check all outputs.
    task automatic cyc(input bit st, input logic [31:0] b, input bit v, input logic [14:0] p);
        longint s;
        iStart = st; iBias = b; iBias16 = b[15:0]; iValid = v; iProduct = p;
        @(posedge iClk);
        m_vnext = 0;
        if (st) begin
            m_active = 1;
            q.delete();
            m_b32 = longint'($signed(b));
            m_b16 = longint'($signed(b[15:0]));
            e_sum = '0; e_act = '0; e_sum16 = '0; e_act16 = '0;
        end else if (m_active && v) begin
            q.push_back(p);
            if (q.size() == TERMS) begin
                m_active = 0;
                m_vnext  = 1;
                s = ref_sum(m_b32, 32); e_sum   = s[31:0]; e_act   = ref_act(s);
                s = ref_sum(m_b16, 16); e_sum16 = s[15:0]; e_act16 = ref_act(s);
            end
        end
        #1;
        chk_outs();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_sum"},   {32'd0, oSum},   64'd0);
        chk({nm, "_act"},   {56'd0, oAct},   64'd0);
        chk({nm, "_valid"}, {63'd0, oValid}, 64'd0);
        chk({nm, "_ready"}, {63'd0, oReady}, 64'd0);
        chk({nm, "_busy"},  {63'd0, oBusy},  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   guard;
        bit   st, vv;
        logic [31:0] b;

        tbl.push_back(mk(32'h0000_0000, 15'h0100, 15'h0080, 15'h4040, 15'h0000, 32'd320,      8'h02, 16'h0140));
        tbl.push_back(mk(32'hFFFF_FC18, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 32'hFFFF_FC18, 8'h00, 16'hFC18));
        tbl.push_back(mk(32'hFFFF_FC18, 15'h4000, 15'h4000, 15'h4000, 15'h4000, 32'hFFFF_FC18, 8'h00, 16'hFC18));
        tbl.push_back(mk(32'h0000_0000, 15'h3FFF, 15'h3FFF, 15'h3FFF, 15'h3FFF, 32'd65532,    8'h7f, 16'h7FFF));
        tbl.push_back(mk(32'h0000_7F00, 15'h3FFF, 15'h3FFF, 15'h3FFF, 15'h3FFF, 32'h0001_7EFC, 8'h7f, 16'h7FFF));
        tbl.push_back(mk(32'h7FFF_FF00, 15'h3FFF, 15'h3FFF, 15'h3FFF, 15'h3FFF, 32'h7FFF_FFFF, 8'h7f, 16'h7FFF));
        tbl.push_back(mk(32'h8000_0100, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF, 32'h8000_0000, 8'h00, 16'h8000));
        tbl.push_back(mk(32'h0000_3F80, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 32'h0000_3F80, 8'h7f, 16'h3F80));
        tbl.push_back(mk(32'h0000_3F7F, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 32'h0000_3F7F, 8'h7e, 16'h3F7F));
        tbl.push_back(mk(32'h0000_4000, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 32'h0000_4000, 8'h7f, 16'h4000));
        tbl.push_back(mk(32'h0000_0001, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 32'h0000_0001, 8'h00, 16'h0001));

        iRst = 1; iStart = 0; iValid = 0; iBias = '0; iBias16 = '0; iProduct = '0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge iClk);
        #1;
        iRst = 0;
        chk_zero("reset_hold");
        cyc(0, 32'd0, 1, 15'h0123);   // iValid ignored while idle

        // constant vectors
        foreach (tbl[i]) begin
            v = tbl[i];
            cyc(1, v.bias, 0, 15'h0000);
            for (int k = 0; k < TERMS; k++) cyc(0, 32'd0, 1, v.p[k]);
            chk("tbl_sum",   {32'd0, oSum},   {32'd0, v.sum});
            chk("tbl_act",   {56'd0, oAct},   {56'd0, v.act});
            chk("tbl_sum16", {48'd0, oSum16}, {48'd0, v.sum16});
            cyc(0, 32'd0, 0, 15'h0000);
            cyc(0, 32'd0, 0, 15'h0000);
        end

        // gappy iValid: accepts at positions 0,3,5,6 -> 1+4+6+7
        cyc(1, 32'd0, 0, 15'h0000);
        begin
            bit pat[7] = '{1, 0, 0, 1, 0, 1, 1};
            for (int k = 0; k < 7; k++) cyc(0, 32'd0, pat[k], 15'(k + 1));
        end
        chk("gap_sum", {32'd0, oSum}, 64'd18);
        cyc(0, 32'd0, 0, 15'h0000);

        // abort after two accepts; product offered with the restart is dropped
        cyc(1, 32'd0, 0, 15'h0000);
        cyc(0, 32'd0, 1, 15'h0005);
        cyc(0, 32'd0, 1, 15'h0005);
        cyc(1, 32'd5, 1, 15'h0100);
        for (int k = 0; k < TERMS; k++) cyc(0, 32'd0, 1, 15'h0001);
        chk("abort_sum", {32'd0, oSum}, 64'd9);
        cyc(0, 32'd0, 0, 15'h0000);

        // asynchronous reset between edges in the middle of accumulation
        cyc(1, 32'd123, 0, 15'h0000);
        cyc(0, 32'd0, 1, 15'h0050);
        cyc(0, 32'd0, 1, 15'h0050);
        iStart = 0; iValid = 0;
        #3;
        iRst = 1;
        #1;
        chk_zero("async_rst");
        m_active = 0; m_vnext = 0; q.delete();
        e_sum = '0; e_act = '0; e_sum16 = '0; e_act16 = '0;
        @(posedge iClk);
        #1;
        iRst = 0;
        cyc(1, 32'd0, 0, 15'h0000);
        for (int k = 0; k < TERMS; k++) cyc(0, 32'd0, 1, 15'h0002);
        chk("post_rst_sum", {32'd0, oSum}, 64'd8);

        // start held during DONE: no idle gap, previous sum clears on that edge
        cyc(1, 32'd0, 0, 15'h0000);
        for (int k = 0; k < TERMS; k++) cyc(0, 32'd0, 1, 15'h0080);
        chk("b2b_first_sum", {32'd0, oSum}, 64'd512);
        chk("b2b_first_act", {56'd0, oAct}, 64'd4);
        cyc(1, 32'd10, 0, 15'h0000);
        chk("b2b_cleared", {32'd0, oSum}, 64'd0);
        for (int k = 0; k < TERMS; k++) cyc(0, 32'd0, 1, 15'h4001);
        chk("b2b_second_sum", {32'd0, oSum}, 64'd6);
        cyc(0, 32'd0, 0, 15'h0000);

        // random neurons
        for (int n = 0; n < 60; n++) begin
            b = (n % 3 == 0) ? $urandom : 32'($signed(13'($urandom)));
            cyc(1, b, 0, 15'h0000);
            guard = 0;
            while (!m_vnext && guard < 300) begin
                st = ($urandom_range(0, 49) == 0);
                vv = ($urandom_range(0, 2) != 0);
                cyc(st, st ? $urandom : 32'd0, vv, 15'($urandom));
                guard++;
            end
            if (guard >= 300) chk("rand_timeout", 64'd0, 64'd1);
            if ($urandom_range(0, 1) == 1) cyc(0, 32'd0, 0, 15'h0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
